bus_trace: RTL and testbench
============================

BUS_TRACE -- requirements
Module: bus_trace

Interface
REQ-001 Parameter WORD_W, default 8, width of the traced system bus.
REQ-002 Parameter DEPTH, default 16, trace buffer entries; a power of two, at least 4.
REQ-003 Local parameter PW = $clog2(DEPTH), pointer width.
REQ-004 clock  in  1  single clock, all logic on rising edge.
REQ-005 n_reset  in  1  synchronous, active-low reset.
REQ-006 sysbus  in  WORD_W  tapped CPU system bus value.
REQ-007 sample_en  in  1  bus qualifier; sysbus sampled only when 1.
REQ-008 arm  in  1  start-capture request, level sampled each cycle.
REQ-009 trig_value  in  WORD_W  trigger compare value.
REQ-010 trig_mask  in  WORD_W  per-bit compare enable (1 = compared).
REQ-011 post_count  in  PW+1  samples stored after the trigger sample.
REQ-012 rd_req  in  1  readout request, one word per cycle.
REQ-013 rd_data  out  WORD_W  readout word.
REQ-014 rd_valid  out  1  rd_data valid.
REQ-015 rd_last  out  1  final word of the trace, coincident with rd_valid.
REQ-016 state  out  2  IDLE=00, ARMED=01, POST=10, DONE=11.
REQ-017 trig_pos  out  PW  readout index of the trigger sample; valid in DONE.
REQ-018 fill  out  PW+1  stored sample count, saturating at DEPTH.

Function
REQ-019 IDLE: arm=1 -> ARMED next cycle; write pointer and fill cleared to 0.
REQ-020 ARMED/POST: each sample_en=1 cycle writes sysbus to mem[wr_ptr]; wr_ptr increments modulo DEPTH; fill increments, saturating at DEPTH.
REQ-021 Trigger: ARMED, sample_en=1, and ((sysbus ^ trig_value) & trig_mask) == 0; the trigger sample is always written.
REQ-022 On trigger: post_count = 0 -> DONE; otherwise -> POST with remaining = min(post_count, DEPTH-1).
REQ-023 POST: remaining decrements per stored sample; the write that brings it to 0 moves to DONE next cycle.
REQ-024 sample_en=0: no write, no pointer, fill or remaining change, no trigger.
REQ-025 trig_mask = 0: trigger on the first sampled cycle in ARMED.
REQ-026 post_count > DEPTH-1: clamped to DEPTH-1, so the trigger sample is never overwritten.
REQ-027 DONE readout order: oldest first; start index 0 if fill < DEPTH, else wr_ptr; exactly fill words.
REQ-028 rd_req=1 in DONE with words remaining: next cycle rd_valid=1 with the next word; back-to-back reads give one word per cycle.
REQ-029 rd_last=1 with the fill-th word; the cycle after that word returns to IDLE.
REQ-030 rd_req outside DONE: ignored; rd_valid stays 0.
REQ-031 trig_pos = fill - 1 - clamped post_count, latched on entry to DONE.
REQ-032 arm in ARMED or POST: ignored.
REQ-033 arm in DONE: abandons readout, enters ARMED, clears fill and pointers.
REQ-034 arm and rd_req together in DONE: arm wins; no rd_valid is issued.
REQ-035 rd_valid and rd_last are registered outputs; all other outputs are registered or decoded directly from registers.

Reset
REQ-036 n_reset=0 at a clock edge, from any state including mid-capture or mid-readout: state=IDLE, fill=0, pointers=0, remaining=0, trig_pos=0, rd_valid=0, rd_last=0, rd_data=0.
REQ-037 Trace memory contents are not cleared by reset; they are unreadable until the next completed capture.
REQ-038 The first clock edge with n_reset=1 is an ordinary IDLE cycle; arm is honoured on it.

Verification (WORD_W=8, DEPTH=16)
REQ-039 Wrap: arm; sysbus counts 0x00 upward, sample_en=1; trig_value=0x20, trig_mask=0xFF, post_count=3 -> DONE after 0x23; 16 reads return 0x14..0x23; rd_last on 0x23; trig_pos=12.
REQ-040 Early trigger: trig_value=0x02, post_count=1 -> fill=4; reads return 0x00..0x03; trig_pos=2.
REQ-041 Mask zero, post_count=0: DONE after the first sample; one read with rd_last=1; then IDLE.
REQ-042 Gapped sampling: sample_en=1 only on values 0x10, 0x12, 0x15; trigger on 0x15, post_count=0 -> reads return 0x10, 0x12, 0x15.
REQ-043 n_reset=0 for one cycle in POST -> state=00, fill=0, rd_valid=0; rd_req afterwards gives no rd_valid.
REQ-044 arm asserted in DONE after 3 of 16 reads -> state=01, fill=0; a new capture completes normally.

Source files
------------

// File: rtl/bus_trace.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_trace : triggered circular trace buffer for a system bus, oldest-first readout
// Rev 1.0
// ---------------------------------------------------------------------------
module bus_trace #(
  parameter int  WORD_W = 8,
  parameter int  DEPTH  = 16,
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] sysbus,
  input  logic              sample_en,
  input  logic              arm,
  input  logic [WORD_W-1:0] trig_value,
  input  logic [WORD_W-1:0] trig_mask,
  input  logic [PW:0]       post_count,
  input  logic              rd_req,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [1:0]        state,
  output logic [PW-1:0]     trig_pos,
  output logic [PW:0]       fill
);

  localparam logic [1:0]  S_IDLE  = 2'b00;
  localparam logic [1:0]  S_ARMED = 2'b01;
  localparam logic [1:0]  S_POST  = 2'b10;
  localparam logic [1:0]  S_DONE  = 2'b11;
  localparam logic [PW:0] c_depth    = (PW+1)'(DEPTH);
  localparam logic [PW:0] c_max_post = (PW+1)'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_remaining;
  logic [PW-1:0]     r_clamp;
  logic [PW-1:0]     r_trig_pos;
  logic [PW:0]       r_fill;
  logic [PW:0]       r_rd_cnt;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_write;
  logic              w_trig;
  logic              w_rd_go;
  logic              w_clear;
  logic              w_enter_done;
  logic [PW:0]       w_fill_inc;
  logic [PW-1:0]     w_wr_ptr_inc;
  logic [PW-1:0]     w_post_clamp;
  logic [PW-1:0]     w_clamp_now;

  always_comb begin
    w_write      = sample_en && (r_state == S_ARMED || r_state == S_POST);
    w_trig       = (r_state == S_ARMED) && sample_en &&
                   (((sysbus ^ trig_value) & trig_mask) == '0);
    w_clear      = arm && (r_state == S_IDLE || r_state == S_DONE);
    // arm in DONE takes priority over a pending read
    w_rd_go      = (r_state == S_DONE) && rd_req && !arm && (r_rd_cnt < r_fill);
    w_fill_inc   = (r_fill == c_depth) ? r_fill : r_fill + (PW+1)'(1);
    w_wr_ptr_inc = r_wr_ptr + PW'(1);
    w_post_clamp = (post_count > c_max_post) ? c_max_post[PW-1:0] : post_count[PW-1:0];
    w_clamp_now  = (r_state == S_ARMED) ? w_post_clamp : r_clamp;
    w_enter_done = (w_next_state == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (arm) w_next_state = S_ARMED;
      S_ARMED: if (w_trig) w_next_state = (post_count == '0) ? S_DONE : S_POST;
      S_POST:  if (w_write && r_remaining == PW'(1)) w_next_state = S_DONE;
      S_DONE: begin
        if (arm)            w_next_state = S_ARMED;
        else if (r_rd_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    state    = r_state;
    fill     = r_fill;
    trig_pos = r_trig_pos;
    rd_data  = r_rd_data;
    rd_valid = r_rd_valid;
    rd_last  = r_rd_last;
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_remaining <= '0;
      r_clamp     <= '0;
      r_trig_pos  <= '0;
      r_fill      <= '0;
      r_rd_cnt    <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      if (w_clear) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_remaining <= '0;
        r_fill      <= '0;
        r_rd_cnt    <= '0;
      end else begin
        if (w_write) begin
          r_wr_ptr <= w_wr_ptr_inc;
          r_fill   <= w_fill_inc;
        end
        if (w_trig) begin
          r_remaining <= w_post_clamp;
          r_clamp     <= w_post_clamp;
        end else if (w_write && r_state == S_POST) begin
          r_remaining <= r_remaining - PW'(1);
        end
        // A full buffer wraps, so the oldest entry sits at the next write slot
        if (w_enter_done) begin
          r_trig_pos <= w_fill_inc[PW-1:0] - PW'(1) - w_clamp_now;
          r_rd_cnt   <= '0;
          r_rd_ptr   <= (w_fill_inc == c_depth) ? w_wr_ptr_inc : '0;
        end
        if (w_rd_go) begin
          r_rd_data  <= r_mem[r_rd_ptr];
          r_rd_ptr   <= r_rd_ptr + PW'(1);
          r_rd_cnt   <= r_rd_cnt + (PW+1)'(1);
          r_rd_valid <= 1'b1;
          r_rd_last  <= ((r_rd_cnt + (PW+1)'(1)) == r_fill);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (n_reset && w_write) begin
      r_mem[r_wr_ptr] <= sysbus;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_trace.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_trace : directed and random stimulus against a queue-based trace model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bus_trace;
  localparam int WORD_W = 8;
  localparam int DEPTH  = 16;
  localparam int PW     = 4;

  logic              clock = 1'b0;
  logic              n_reset;
  logic [WORD_W-1:0] sysbus;
  logic              sample_en;
  logic              arm;
  logic [WORD_W-1:0] trig_value;
  logic [WORD_W-1:0] trig_mask;
  logic [PW:0]       post_count;
  logic              rd_req;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic [1:0]        state;
  logic [PW-1:0]     trig_pos;
  logic [PW:0]       fill;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: the trace is a queue of the most recent DEPTH stored samples
  logic [7:0] m_q[$];
  int         m_state  = 0;
  int         m_rem    = 0;
  int         m_clamp  = 0;
  int         m_rd_idx = 0;
  int         m_tp     = 0;
  bit         m_valid  = 1'b0;
  bit         m_last   = 1'b0;
  logic [7:0] m_data   = 8'h00;

  always #5 clock = ~clock;

  bus_trace #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .n_reset(n_reset), .sysbus(sysbus), .sample_en(sample_en),
    .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
    .post_count(post_count), .rd_req(rd_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .state(state),
    .trig_pos(trig_pos), .fill(fill)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task m_enter_done();
    m_state  = 3;
    m_tp     = m_q.size() - 1 - m_clamp;
    m_rd_idx = 0;
  endtask

  always @(posedge clock) begin
    bit nv;
    bit nl;
    nv = 1'b0;
    nl = 1'b0;
    if (!n_reset) begin
      m_state = 0; m_q.delete(); m_rem = 0; m_tp = 0; m_rd_idx = 0; m_data = 8'h00;
    end else begin
      case (m_state)
        0: if (arm) begin m_q.delete(); m_state = 1; end
        1, 2: if (sample_en) begin
          m_q.push_back(sysbus);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m_state == 1) begin
            if (((sysbus ^ trig_value) & trig_mask) == 8'h00) begin
              m_clamp = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
              if (m_clamp == 0) m_enter_done();
              else begin m_state = 2; m_rem = m_clamp; end
            end
          end else begin
            m_rem--;
            if (m_rem == 0) m_enter_done();
          end
        end
        default: begin
          if (arm) begin m_q.delete(); m_state = 1; m_rd_idx = 0; end
          else if (m_last) m_state = 0;
          else if (rd_req && m_rd_idx < m_q.size()) begin
            m_data = m_q[m_rd_idx];
            m_rd_idx++;
            nv = 1'b1;
            nl = (m_rd_idx == m_q.size());
          end
        end
      endcase
    end
    m_valid = nv;
    m_last  = nl;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("state", int'(state), m_state);
      chk("fill", int'(fill), m_q.size());
      chk("rd_valid", int'(rd_valid), int'(m_valid));
      chk("rd_last", int'(rd_last), int'(m_last));
      if (m_valid) chk("rd_data", int'(rd_data), int'(m_data));
      if (m_state == 3) chk("trig_pos", int'(trig_pos), m_tp);
    end
  end

  task automatic cap_count(input logic [7:0] tv, input logic [7:0] tm,
                           input logic [PW:0] pc, output int lastv);
    int v;
    v = 0;
    trig_value = tv; trig_mask = tm; post_count = pc;
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    sample_en = 1'b1;
    sysbus = 8'(v);
    for (int n = 0; n < 200 && state != 2'b11; n++) begin
      @(negedge clock);
      if (state != 2'b11) begin v++; sysbus = 8'(v); end
    end
    sample_en = 1'b0;
    chk("capture_done", int'(state), 3);
    lastv = v;
  endtask

  task automatic read_run(input int first, input int n, input bit last_at_end);
    rd_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("lit_rd_valid", int'(rd_valid), 1);
      chk("lit_rd_data", int'(rd_data), (first + i) & 8'hFF);
      chk("lit_rd_last", int'(rd_last), int'(last_at_end && i == n - 1));
    end
    rd_req = 1'b0;
  endtask

  initial begin
    int v;
    logic [7:0] exp3 [3];
    exp3 = '{8'h10, 8'h12, 8'h15};
    n_reset = 1'b0; sysbus = '0; sample_en = 1'b0; arm = 1'b0;
    trig_value = '0; trig_mask = '0; post_count = '0; rd_req = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_state", int'(state), 0);
    chk("rst_fill", int'(fill), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_trig_pos", int'(trig_pos), 0);
    n_reset = 1'b1;
    chk_en = 1'b1;

    // Wrap-around capture
    cap_count(8'h20, 8'hFF, 5'd3, v);
    chk("wrap_last_sample", v, 8'h23);
    chk("wrap_fill", int'(fill), 16);
    chk("wrap_trig_pos", int'(trig_pos), 12);
    read_run(8'h14, 16, 1'b1);
    @(negedge clock);
    chk("wrap_idle", int'(state), 0);

    // Early trigger before the buffer fills
    cap_count(8'h02, 8'hFF, 5'd1, v);
    chk("early_fill", int'(fill), 4);
    chk("early_trig_pos", int'(trig_pos), 2);
    read_run(8'h00, 4, 1'b1);
    @(negedge clock);
    chk("early_idle", int'(state), 0);

    // Zero mask, zero post count
    trig_mask = 8'h00; post_count = 5'd0; arm = 1'b1;
    @(negedge clock);
    arm = 1'b0; sysbus = 8'h55; sample_en = 1'b1;
    @(negedge clock);
    sample_en = 1'b0;
    chk("mask0_state", int'(state), 3);
    chk("mask0_fill", int'(fill), 1);
    read_run(8'h55, 1, 1'b1);
    @(negedge clock);
    chk("mask0_idle", int'(state), 0);

    // Gapped sampling
    trig_value = 8'h15; trig_mask = 8'hFF; post_count = 5'd0; arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    for (int x = 16; x <= 21; x++) begin
      sysbus = 8'(x);
      sample_en = (x == 16 || x == 18 || x == 21);
      @(negedge clock);
    end
    sample_en = 1'b0;
    chk("gap_state", int'(state), 3);
    chk("gap_fill", int'(fill), 3);
    chk("gap_trig_pos", int'(trig_pos), 2);
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("gap_rd_data", int'(rd_data), int'(exp3[i]));
      chk("gap_rd_last", int'(rd_last), int'(i == 2));
    end
    rd_req = 1'b0;
    @(negedge clock);

    // Reset during POST
    trig_value = 8'h20; trig_mask = 8'hFF; post_count = 5'd3; arm = 1'b1;
    @(negedge clock);
    arm = 1'b0; v = 0; sysbus = 8'h00; sample_en = 1'b1;
    for (int n = 0; n < 100 && state != 2'b10; n++) begin
      @(negedge clock);
      if (state != 2'b10) begin v++; sysbus = 8'(v); end
    end
    chk("post_reached", int'(state), 2);
    n_reset = 1'b0;
    @(negedge clock);
    n_reset = 1'b1; sample_en = 1'b0;
    chk("post_rst_state", int'(state), 0);
    chk("post_rst_fill", int'(fill), 0);
    chk("post_rst_rd_valid", int'(rd_valid), 0);
    rd_req = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_no_read", int'(rd_valid), 0);
    end
    rd_req = 1'b0;

    // Re-arm during readout
    cap_count(8'h20, 8'hFF, 5'd3, v);
    read_run(8'h14, 3, 1'b0);
    arm = 1'b1; rd_req = 1'b1;
    @(negedge clock);
    arm = 1'b0; rd_req = 1'b0;
    chk("rearm_state", int'(state), 1);
    chk("rearm_fill", int'(fill), 0);
    chk("rearm_rd_valid", int'(rd_valid), 0);
    cap_count(8'h20, 8'hFF, 5'd3, v);
    chk("rearm_trig_pos", int'(trig_pos), 12);
    read_run(8'h14, 16, 1'b1);
    @(negedge clock);
    chk("rearm_idle", int'(state), 0);

    // Random traffic, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      n_reset   = ($urandom_range(0, 199) != 0);
      arm       = ($urandom_range(0, 24) == 0);
      sample_en = ($urandom_range(0, 9) < 7);
      sysbus    = 8'($urandom);
      rd_req    = ($urandom_range(0, 9) < 7);
      if (arm) begin
        trig_value = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       trig_mask = 8'h00;
          1:       trig_mask = 8'h01;
          2:       trig_mask = 8'h03;
          default: trig_mask = 8'h07;
        endcase
        post_count = 5'($urandom_range(0, 31));
      end
    end
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
